// File: rtl/irrigacao_multizona_if.sv
// Signal bundle between the multi-zone irrigation controller and its surroundings:
// reservoir probes, per-zone sensors, display select and every registered output.
interface irrigacao_multizona_if #(
    parameter int ZONES = 4
);
    logic             nivel_a;
    logic             nivel_m;
    logic             nivel_b;
    logic [ZONES-1:0] us;
    logic [ZONES-1:0] ua;
    logic [ZONES-1:0] t_alta;
    logic             sel_exib;
    logic             al;
    logic             ve;
    logic [ZONES-1:0] gt;
    logic [ZONES-1:0] asp;
    logic [2:0]       zona_ativa;
    logic [6:0]       seg;

    modport master (
        output nivel_a, nivel_m, nivel_b, us, ua, t_alta, sel_exib,
        input  al, ve, gt, asp, zona_ativa, seg
    );

    modport slave (
        input  nivel_a, nivel_m, nivel_b, us, ua, t_alta, sel_exib,
        output al, ve, gt, asp, zona_ativa, seg
    );
endinterface

// File: rtl/irrigacao_multizona.sv
// Shared-reservoir supervisor (alarm, fill valve with hysteresis) plus a round-robin
// scheduler running timed drip or sprinkler cycles per zone, and a 7-segment digit.
module irrigacao_multizona #(
    parameter int ZONES  = 4,
    parameter int DUR_GT = 16,
    parameter int DUR_AS = 8
) (
    input logic                clk,
    input logic                rst_n,
    irrigacao_multizona_if.slave bus
);
    localparam int DUR_MAX = (DUR_GT > DUR_AS) ? DUR_GT : DUR_AS;
    localparam int CNT_W   = $clog2(DUR_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_GT   = CNT_W'(DUR_GT);
    localparam logic [CNT_W-1:0] CNT_AS   = CNT_W'(DUR_AS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       PTR_LAST = 3'(ZONES - 1);

    typedef enum logic [1:0] {IDLE, REGA, PAUSA} state_t;

    state_t           state;
    logic [2:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic             al_q;
    logic             ve_q;
    logic [ZONES-1:0] gt_q;
    logic [ZONES-1:0] asp_q;
    logic [2:0]       zona_q;
    logic [6:0]       seg_q;

    logic             fault;
    logic             empty;
    logic [1:0]       lvl;
    logic             us_cur;
    logic             ua_cur;
    logic             ta_cur;
    logic [ZONES-1:0] zone_bit;
    logic [2:0]       ptr_next;
    logic [6:0]       seg_next;

    function automatic logic [6:0] seg_digit(input logic [2:0] d);
        case (d)
            3'd0:    seg_digit = 7'b1111110;
            3'd1:    seg_digit = 7'b0110000;
            3'd2:    seg_digit = 7'b1101101;
            3'd3:    seg_digit = 7'b1111001;
            3'd4:    seg_digit = 7'b0110011;
            3'd5:    seg_digit = 7'b1011011;
            3'd6:    seg_digit = 7'b1011111;
            default: seg_digit = 7'b1110000;
        endcase
    endfunction

    assign fault    = (bus.nivel_a & ~bus.nivel_m) | (bus.nivel_m & ~bus.nivel_b);
    assign empty    = ~bus.nivel_b;
    assign lvl      = 2'(bus.nivel_a) + 2'(bus.nivel_m) + 2'(bus.nivel_b);
    assign zone_bit = ZONES'(1) << ptr;
    assign ptr_next = (ptr == PTR_LAST) ? 3'd0 : ptr + 3'd1;

    // Sensor bits of the zone under the pointer.
    always_comb begin
        us_cur = 1'b0;
        ua_cur = 1'b0;
        ta_cur = 1'b0;
        for (int i = 0; i < ZONES; i++) begin
            if (ptr == 3'(i)) begin
                us_cur = bus.us[i];
                ua_cur = bus.ua[i];
                ta_cur = bus.t_alta[i];
            end
        end
    end

    always_comb begin
        seg_next = 7'b0000001;
        if (!bus.sel_exib)
            seg_next = fault ? 7'b1001111 : seg_digit({1'b0, lvl});
        else if (state == REGA)
            seg_next = seg_digit(ptr);
    end

    // Reservoir supervision: set below medium, clear at high or on fault, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            al_q  <= 1'b0;
            ve_q  <= 1'b0;
            seg_q <= 7'b1111110;
        end else begin
            al_q  <= fault | empty;
            seg_q <= seg_next;
            if (bus.nivel_a || fault)
                ve_q <= 1'b0;
            else if (!bus.nivel_m)
                ve_q <= 1'b1;
        end
    end

    // Scheduler; the enable vectors themselves hold the mode chosen at cycle start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 3'd0;
            cnt    <= '0;
            gt_q   <= '0;
            asp_q  <= '0;
            zona_q <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (us_cur && !al_q) begin
                        state  <= REGA;
                        zona_q <= ptr;
                        if (ta_cur && !ua_cur) begin
                            asp_q <= zone_bit;
                            cnt   <= CNT_AS;
                        end else begin
                            gt_q <= zone_bit;
                            cnt  <= CNT_GT;
                        end
                    end else begin
                        ptr <= ptr_next;
                    end
                end
                REGA: begin
                    if (cnt <= CNT_ONE || !us_cur || al_q) begin
                        state  <= PAUSA;
                        cnt    <= '0;
                        gt_q   <= '0;
                        asp_q  <= '0;
                        zona_q <= 3'd0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                PAUSA: begin
                    state <= IDLE;
                    ptr   <= ptr_next;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.al         = al_q;
    assign bus.ve         = ve_q;
    assign bus.gt         = gt_q;
    assign bus.asp        = asp_q;
    assign bus.zona_ativa = zona_q;
    assign bus.seg        = seg_q;
endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench for irrigacao_multizona: level/valve/display table plus drip,
// sprinkler, alarm-abort and asynchronous-reset sequences.
module tb_irrigacao_multizona;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irrigacao_multizona_if #(.ZONES(4)) bus ();

    irrigacao_multizona #(
        .ZONES (4),
        .DUR_GT(16),
        .DUR_AS(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       a;
        logic       m;
        logic       b;
        logic       sel;
        logic       al;
        logic       ve;
        logic [6:0] seg;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic probes(input logic a, input logic m, input logic b);
        bus.nivel_a = a;
        bus.nivel_m = m;
        bus.nivel_b = b;
    endtask

    task automatic wait_start();
        int k;
        k = 0;
        while ((bus.gt | bus.asp) == 4'b0000 && k < 20) begin
            step();
            k++;
        end
    endtask

    initial begin
        int   cnt;
        int   k;
        logic seen;

        checks = 0;
        errors = 0;
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111001};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 7'b0110000};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 7'b1101101};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111001};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1101101};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 7'b1111110};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b1001111};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7'b1001111};
        vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 7'b0000001};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'b1111001};

        rst_n = 1'b0;
        probes(1'b1, 1'b1, 1'b1);
        bus.us       = 4'b0000;
        bus.ua       = 4'b0000;
        bus.t_alta   = 4'b0000;
        bus.sel_exib = 1'b0;
        repeat (3) step();
        chk("rst_al", 32'(bus.al), 32'd0);
        chk("rst_ve", 32'(bus.ve), 32'd0);
        chk("rst_gt", 32'(bus.gt | bus.asp), 32'd0);
        chk("rst_zona", 32'(bus.zona_ativa), 32'd0);
        chk("rst_seg", 32'(bus.seg), 32'(7'b1111110));
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            probes(vecs[i].a, vecs[i].m, vecs[i].b);
            bus.sel_exib = vecs[i].sel;
            step();
            chk($sformatf("v%0d_al", i), 32'(bus.al), 32'(vecs[i].al));
            chk($sformatf("v%0d_ve", i), 32'(bus.ve), 32'(vecs[i].ve));
            chk($sformatf("v%0d_seg", i), 32'(bus.seg), 32'(vecs[i].seg));
            chk($sformatf("v%0d_out", i), 32'(bus.gt | bus.asp), 32'd0);
            chk($sformatf("v%0d_zona", i), 32'(bus.zona_ativa), 32'd0);
        end

        // Drip cycle on zone 2, then the scan must continue at zone 3.
        bus.sel_exib = 1'b1;
        bus.us = 4'b0100;
        bus.ua = 4'b0100;
        wait_start();
        chk("a_gt", 32'(bus.gt), 32'(4'b0100));
        chk("a_asp", 32'(bus.asp), 32'd0);
        chk("a_zona", 32'(bus.zona_ativa), 32'd2);
        cnt = 0;
        k = 0;
        while (bus.gt[2] && k < 40) begin
            cnt++;
            if (cnt == 2) chk("a_seg", 32'(bus.seg), 32'(7'b1101101));
            step();
            k++;
        end
        chk("a_len", 32'(cnt), 32'd16);
        chk("a_pausa_zona", 32'(bus.zona_ativa), 32'd0);
        bus.us = 4'b1000;
        bus.ua = 4'b1000;
        step();
        chk("a_idle_z3", 32'(bus.gt | bus.asp), 32'd0);
        step();
        chk("a_next_gt", 32'(bus.gt), 32'(4'b1000));
        chk("a_next_zona", 32'(bus.zona_ativa), 32'd3);
        bus.us = 4'b0000;
        step();
        chk("a_early_exit", 32'(bus.gt | bus.asp), 32'd0);

        // Sprinkler on zone 1; ua toggling mid-cycle must not switch to drip.
        bus.us     = 4'b0010;
        bus.ua     = 4'b0000;
        bus.t_alta = 4'b0010;
        wait_start();
        chk("b_asp", 32'(bus.asp), 32'(4'b0010));
        chk("b_gt", 32'(bus.gt), 32'd0);
        cnt = 0;
        k = 0;
        seen = 1'b0;
        while (bus.asp[1] && k < 40) begin
            cnt++;
            if (cnt == 3) bus.ua = 4'b0010;
            if (bus.gt != 4'b0000) seen = 1'b1;
            step();
            k++;
        end
        chk("b_len", 32'(cnt), 32'd8);
        chk("b_no_gt", 32'(seen), 32'd0);
        bus.us     = 4'b0000;
        bus.ua     = 4'b0000;
        bus.t_alta = 4'b0000;

        // Alarm abort during drip on zone 0.
        bus.us = 4'b0001;
        bus.ua = 4'b0001;
        wait_start();
        chk("c_gt", 32'(bus.gt), 32'(4'b0001));
        step();
        step();
        probes(1'b1, 1'b1, 1'b0);
        step();
        chk("c_al", 32'(bus.al), 32'd1);
        chk("c_gt_hold", 32'(bus.gt), 32'(4'b0001));
        step();
        chk("c_abort", 32'(bus.gt | bus.asp), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if ((bus.gt | bus.asp) != 4'b0000) seen = 1'b1;
        end
        chk("c_no_start", 32'(seen), 32'd0);

        // Asynchronous reset in the middle of a watering cycle.
        bus.sel_exib = 1'b0;
        probes(1'b0, 1'b0, 1'b1);
        wait_start();
        step();
        step();
        chk("d_gt", 32'(bus.gt), 32'(4'b0001));
        chk("d_ve", 32'(bus.ve), 32'd1);
        chk("d_seg", 32'(bus.seg), 32'(7'b0110000));
        #3;
        rst_n = 1'b0;
        #1;
        chk("d_rst_gt", 32'(bus.gt | bus.asp), 32'd0);
        chk("d_rst_ve", 32'(bus.ve), 32'd0);
        chk("d_rst_al", 32'(bus.al), 32'd0);
        chk("d_rst_zona", 32'(bus.zona_ativa), 32'd0);
        chk("d_rst_seg", 32'(bus.seg), 32'(7'b1111110));
        #2;
        rst_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/irrigacao_multizona.md
# irrigacao_multizona

Parametrised, clocked successor of the single-zone irrigation controller. It supervises one shared reservoir through three level probes, raising the alarm and driving the fill valve with hysteresis. It serves ZONES irrigation zones one at a time through a round-robin scheduler, with timed drip or sprinkler cycles per zone. It drives one 7-segment digit, showing either reservoir level or the active zone.

## Interface
- ZONES, 4, number of zones; legal 1..8
- DUR_GT, 16, drip cycle length in clocks; ≥1
- DUR_AS, 8, sprinkler cycle length in clocks; ≥1
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- nivel_a / nivel_m / nivel_b  in  1 each  high / medium / low level probes, 1 = water at probe
- us  in  ZONES  per-zone soil dry (1 = needs water)
- ua  in  ZONES  per-zone air humid
- t_alta  in  ZONES  per-zone high temperature
- sel_exib  in  1  display select: 0 = level, 1 = zone
- al  out  1  alarm
- ve  out  1  fill valve open
- gt  out  ZONES  drip enable, one-hot or zero
- asp  out  ZONES  sprinkler enable, one-hot or zero
- zona_ativa  out  3  index of the zone being watered; 0 when idle
- seg  out  7  {a,b,c,d,e,f,g}, active-high

All inputs are synchronous to clk. All outputs are registered and 0 after reset. The one exception is seg, which shows the level digit of the reset state.

## Operation
- Fault condition is (nivel_a & ~nivel_m) | (nivel_m & ~nivel_b), i.e. an inconsistent probe set. Empty is ~nivel_b.
- al is registered (fault | empty).
- ve sets when ~nivel_m & ~fault.
- ve clears when nivel_a | fault.
- ve otherwise holds its value, giving hysteresis between medium and high.
- Scheduler states and transitions:
  - IDLE, examining zone ptr: if us[ptr] & ~al, go to REGA with the cycle length loaded into the counter. Otherwise ptr advances.
  - Mode is fixed at REGA entry: sprinkler if t_alta[ptr] & ~ua[ptr], else drip. The counter is loaded with DUR_AS or DUR_GT accordingly.
  - REGA: gt[ptr] or asp[ptr] is high and the counter decrements each clock. Go to PAUSA when the counter reaches 1, when us[ptr] drops, or when al rises.
  - PAUSA: one clock with all gt/asp low. ptr advances and the state returns to IDLE.
- ptr advance wraps from ZONES-1 to 0. With ZONES=1 it stays at 0.
- zona_ativa = ptr while in REGA, else 0.
- The counter is clog2(max(DUR_GT,DUR_AS)+1) bits wide and never underflows.
- Display, sel_exib=0:
  - Fault shows 'E' = 1001111.
  - Otherwise the digit is the level count: 3 = 1111001, 2 = 1101101, 1 = 0110000, 0 = 1111110.
- Display, sel_exib=1:
  - In REGA, the digit zona_ativa is shown: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - Otherwise '-' = 0000001.

## Timing
- Reset: state IDLE, ptr 0, counter 0, al/ve/gt/asp/zona_ativa all 0, seg = '0' glyph.
- al and ve update one clock after the probe change.
- IDLE sees demand in cycle n: the watering output is high from cycle n+1 for exactly DUR cycles, then 1 PAUSA cycle. At cycle n+DUR+2 the state is IDLE at ptr+1.
- A zone without demand costs one IDLE cycle per visit. A full empty scan takes ZONES clocks.
- Early exit (us drop or al rise in cycle k): the output is low from cycle k+1.
- Abort on alarm uses the registered al, so outputs drop two clocks after the probe change.
- us/ua/t_alta changes during REGA do not change the mode.
- Never more than one bit of gt|asp is high.
- rst_n low mid-cycle clears all outputs asynchronously, immediately.
- seg reflects sel_exib and state with one clock of latency.

## Test plan
- Reset, then release with probes a=m=b=1 and us=0 → al=0, ve=0, all gt/asp=0, ptr cycles 0..3, seg=1111001.
- Probes b=1, m=0, a=0 → ve=1 next clock. Raise m → ve stays 1. Raise a → ve=0 next clock. Drop a only → ve stays 0.
- us[2]=1, ua[2]=1, level full → gt[2] high for exactly 16 clocks, zona_ativa=2, seg with sel_exib=1 shows 1101101, then 1 PAUSA cycle, scan resumes at zone 3.
- us[1]=1, t_alta[1]=1, ua[1]=0 → asp[1] high exactly 8 clocks. Toggling ua mid-cycle does not switch to gt.
- During REGA on zone 0, drop nivel_b → al=1 next clock, asp/gt low one clock later, no zone starts while al=1.
- Probes a=1, m=0, b=1 → al=1, ve=0, seg (sel_exib=0) = 1001111. Assert rst_n=0 mid-REGA → all outputs 0 immediately.
